// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Owns the program counter, runs the instruction-memory read handshake and
//   holds the fetched word in the instruction register for the control FSM.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   : an 8-bit WAIT counter moves the unit to ERR after
//                 MEM_TIMEOUT consecutive WAIT cycles without mem_ready.
//     undefined : WAIT holds until mem_ready; fetch_err only flags a
//                 misaligned PC.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic        pc_load,
   input  logic [31:0] pc_next,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        busy,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Out-of-range timeout values are rejected at elaboration.
   if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255)) begin : gTimeoutRange
      $error("MEM_TIMEOUT must be in 1..255");
   end

   state_t      state;
   state_t      nextState;
   logic [31:0] pcReg;
   // Set once a PC load lands during a fetch; the completion then must not
   // overwrite the loaded value with the sequential +4.
   logic        pcLoaded;
   logic        startFetch;
   logic        alignErr;
   logic        completeFetch;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
   logic [7:0]  timeoutCnt;
   logic        timeoutHit;
`endif

   assign pc_out   = pcReg;
   assign pc_plus4 = pcReg + 32'd4;
   assign busy     = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode plus the one-cycle event strobes used by the datapath.
   always_comb begin
      nextState     = state;
      startFetch    = 1'b0;
      alignErr      = 1'b0;
      completeFetch = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      timeoutHit    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (fetch_req) begin
               if (pcReg[1:0] == 2'b00) begin
                  nextState  = REQ;
                  startFetch = 1'b1;
               end else begin
                  nextState = ERR;
                  alignErr  = 1'b1;
               end
            end else begin
               nextState = IDLE;
            end
         end
         REQ: begin
            nextState = WAIT;
         end
         WAIT: begin
            if (mem_ready) begin
               nextState     = IDLE;
               completeFetch = 1'b1;
            end else begin
`ifdef FETCH_TIMEOUT_EN
               if (timeoutCnt == TIMEOUT_LAST) begin
                  nextState  = ERR;
                  timeoutHit = 1'b1;
               end else begin
                  nextState = WAIT;
               end
`else
               nextState = WAIT;
`endif
            end
         end
         ERR: begin
            nextState = ERR;
         end
         default: begin
            nextState = ERR;
         end
      endcase
   end

   // PC, memory strobe/address, instruction register and error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcReg       <= PC_RESET;
         pcLoaded    <= 1'b0;
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
         mem_rd      <= 1'b0;
         mem_addr    <= 32'h0000_0000;
         fetch_err   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         timeoutCnt  <= 8'd0;
`endif
      end else begin
         instr_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (pc_load) begin
                  pcReg <= pc_next;
               end
               if (startFetch) begin
                  mem_rd   <= 1'b1;
                  mem_addr <= pcReg;
                  pcLoaded <= pc_load;
               end
               if (alignErr) begin
                  fetch_err <= 1'b1;
               end
            end
            REQ: begin
               if (pc_load) begin
                  pcReg    <= pc_next;
                  pcLoaded <= 1'b1;
               end
`ifdef FETCH_TIMEOUT_EN
               timeoutCnt <= 8'd0;
`endif
            end
            WAIT: begin
               if (completeFetch) begin
                  instr       <= mem_rdata;
                  instr_valid <= 1'b1;
                  mem_rd      <= 1'b0;
                  if (pc_load) begin
                     pcReg <= pc_next;
                  end else if (!pcLoaded) begin
                     pcReg <= pc_plus4;
                  end
               end else begin
                  if (pc_load) begin
                     pcReg    <= pc_next;
                     pcLoaded <= 1'b1;
                  end
`ifdef FETCH_TIMEOUT_EN
                  if (timeoutHit) begin
                     mem_rd    <= 1'b0;
                     fetch_err <= 1'b1;
                  end else begin
                     timeoutCnt <= timeoutCnt + 8'd1;
                  end
`endif
               end
            end
            ERR: begin
               mem_rd <= 1'b0;
            end
            default: begin
               mem_rd <= 1'b0;
            end
         endcase
      end
   end

endmodule
